// File: rtl/tft_timing_ctrl.sv
// tft_timing_ctrl
//   TFT panel controller: power sequencing (EN -> data -> DISP -> backlight and the
//   reverse), H/V timing with DE generation, pixel request handshake towards an
//   upstream pixel source, and a programmable backlight PWM.
// Ports
//   TFT_CLK      pixel clock
//   reset        synchronous active-high reset
//   power_req    1 = panel on requested, 0 = power down
//   pwm_duty     backlight high-time in clocks per PWM period
//   pix_r/g/b    upstream pixel, valid when pix_req=1
//   pix_req      consume pixel this cycle (combinational)
//   frame_start  first active pixel of the frame is being requested (combinational)
//   TFT_EN       panel power enable
//   TFT_DISP     display on
//   TFT_DE       data enable
//   LED_EN       backlight PWM output
//   TFT_R/G/B    pixel data to panel
//   pwr_state    sequencer state (debug)
module tft_timing_ctrl #(
  parameter int COLOR_W    = 8,
  parameter int H_ACTIVE   = 480,
  parameter int H_BLANK    = 45,
  parameter int V_ACTIVE   = 272,
  parameter int V_BLANK    = 16,
  parameter int T1_CYC     = 9000,
  parameter int T2_CYC     = 9000,
  parameter int T3_CYC     = 1440000,
  parameter int T4_CYC     = 900000,
  parameter int PWM_PERIOD = 900,
  parameter int DUTY_W     = 10
) (
  input  logic               TFT_CLK,
  input  logic               reset,
  input  logic               power_req,
  input  logic [DUTY_W-1:0]  pwm_duty,
  input  logic [COLOR_W-1:0] pix_r,
  input  logic [COLOR_W-1:0] pix_g,
  input  logic [COLOR_W-1:0] pix_b,
  output logic               pix_req,
  output logic               frame_start,
  output logic               TFT_EN,
  output logic               TFT_DISP,
  output logic               TFT_DE,
  output logic               LED_EN,
  output logic [COLOR_W-1:0] TFT_R,
  output logic [COLOR_W-1:0] TFT_G,
  output logic [COLOR_W-1:0] TFT_B,
  output logic [2:0]         pwr_state
);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_EN_WAIT   = 3'd1,
    S_DISP_WAIT = 3'd2,
    S_BL_WAIT   = 3'd3,
    S_RUN       = 3'd4,
    S_BL_OFF    = 3'd5,
    S_EN_HOLD   = 3'd6
  } state_t;

  localparam int H_TOT = H_ACTIVE + H_BLANK;
  localparam int V_TOT = V_ACTIVE + V_BLANK;
  localparam int HW    = (H_TOT > 1) ? $clog2(H_TOT) : 1;
  localparam int VW    = (V_TOT > 1) ? $clog2(V_TOT) : 1;
  localparam int PW    = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int T_A   = (T1_CYC > T2_CYC) ? T1_CYC : T2_CYC;
  localparam int T_B   = (T3_CYC > T4_CYC) ? T3_CYC : T4_CYC;
  localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
  localparam int WW    = $clog2(T_MAX + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [PW-1:0] P_LAST = PW'(PWM_PERIOD - 1);
  localparam logic [WW-1:0] T1_C   = WW'(T1_CYC);
  localparam logic [WW-1:0] T2_C   = WW'(T2_CYC);
  localparam logic [WW-1:0] T3_C   = WW'(T3_CYC);
  localparam logic [WW-1:0] T4_C   = WW'(T4_CYC);

  // Panel timing runs from data start until the backlight power-down begins.
  function automatic logic timing_on(input state_t s);
    return (s == S_DISP_WAIT) || (s == S_BL_WAIT) || (s == S_RUN);
  endfunction

  state_t               state_q, state_d;
  logic [WW-1:0]        wcnt_q, wcnt_d;
  logic [HW-1:0]        hcnt_q, hcnt_d;
  logic [VW-1:0]        vcnt_q, vcnt_d;
  logic [PW-1:0]        pcnt_q, pcnt_d;
  logic [DUTY_W-1:0]    duty_q, duty_d;
  logic                 en_q, en_d;
  logic                 disp_q, disp_d;
  logic                 gate_q, gate_d;
  logic                 led_q, led_d;
  logic                 de_q, de_d;
  logic [COLOR_W-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
  logic                 h_wrap_s;

  assign pix_req     = timing_on(state_q) && (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign frame_start = pix_req && (hcnt_q == '0) && (vcnt_q == '0);
  assign h_wrap_s    = (hcnt_q == H_LAST);

  // Power sequencer next state; power_req low aborts any power-up wait.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:       if (power_req) state_d = S_EN_WAIT; else state_d = S_OFF;
      S_EN_WAIT:   if (!power_req) state_d = S_BL_OFF;
                   else if (wcnt_q == T1_C) state_d = S_DISP_WAIT;
                   else state_d = S_EN_WAIT;
      S_DISP_WAIT: if (!power_req) state_d = S_BL_OFF;
                   else if (wcnt_q == T2_C) state_d = S_BL_WAIT;
                   else state_d = S_DISP_WAIT;
      S_BL_WAIT:   if (!power_req) state_d = S_BL_OFF;
                   else if (wcnt_q == T3_C) state_d = S_RUN;
                   else state_d = S_BL_WAIT;
      S_RUN:       if (!power_req) state_d = S_BL_OFF; else state_d = S_RUN;
      S_BL_OFF:    if (wcnt_q == T3_C) state_d = S_EN_HOLD; else state_d = S_BL_OFF;
      S_EN_HOLD:   if (wcnt_q == T4_C) state_d = S_OFF; else state_d = S_EN_HOLD;
      default:     state_d = S_OFF;
    endcase
  end

  // Wait counter (entry clock counts as 1), sequencer outputs, H/V timing, PWM and pixel path.
  always_comb begin
    if (state_d != state_q) begin
      wcnt_d = WW'(1);
    end else if ((state_q == S_OFF) || (state_q == S_RUN)) begin
      wcnt_d = '0;
    end else begin
      wcnt_d = wcnt_q + WW'(1);
    end

    // Outputs follow the state being entered so they change together with pwr_state.
    // DISP only survives into BL_OFF if it had already been raised.
    en_d   = (state_d inside {S_EN_WAIT, S_DISP_WAIT, S_BL_WAIT, S_RUN, S_BL_OFF});
    disp_d = (state_d == S_BL_WAIT) || (state_d == S_RUN) || ((state_d == S_BL_OFF) && disp_q);
    gate_d = (state_d == S_RUN);

    // Counters restart from zero on every entry into the timing-active states.
    if (timing_on(state_q) && timing_on(state_d)) begin
      hcnt_d = h_wrap_s ? '0 : hcnt_q + HW'(1);
      if (h_wrap_s) begin
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
      end else begin
        vcnt_d = vcnt_q;
      end
    end else begin
      hcnt_d = '0;
      vcnt_d = '0;
    end

    // Duty is taken at the start of each period and also used for that first clock.
    pcnt_d = (pcnt_q == P_LAST) ? '0 : pcnt_q + PW'(1);
    duty_d = (pcnt_q == '0) ? pwm_duty : duty_q;
    led_d  = gate_q && ({{DUTY_W{1'b0}}, pcnt_q} < {{PW{1'b0}}, duty_d});

    de_d = pix_req;
    r_d  = pix_req ? pix_r : '0;
    g_d  = pix_req ? pix_g : '0;
    b_d  = pix_req ? pix_b : '0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge TFT_CLK) begin
    if (reset) begin
      state_q <= S_OFF;
      wcnt_q  <= '0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      pcnt_q  <= '0;
      duty_q  <= '0;
      en_q    <= 1'b0;
      disp_q  <= 1'b0;
      gate_q  <= 1'b0;
      led_q   <= 1'b0;
      de_q    <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      pcnt_q  <= pcnt_d;
      duty_q  <= duty_d;
      en_q    <= en_d;
      disp_q  <= disp_d;
      gate_q  <= gate_d;
      led_q   <= led_d;
      de_q    <= de_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign TFT_EN    = en_q;
  assign TFT_DISP  = disp_q;
  assign TFT_DE    = de_q;
  assign LED_EN    = led_q;
  assign TFT_R     = r_q;
  assign TFT_G     = g_q;
  assign TFT_B     = b_q;
  assign pwr_state = state_q;

endmodule

// File: tb/tb_tft_timing_ctrl.sv
module tb_tft_timing_ctrl;

  localparam int CW = 8;
  localparam int HA = 4;
  localparam int HB = 2;
  localparam int VA = 3;
  localparam int VB = 1;
  localparam int T1 = 5;
  localparam int T2 = 3;
  localparam int T3 = 6;
  localparam int T4 = 4;
  localparam int PP = 8;
  localparam int DW = 10;
  localparam int HT = HA + HB;
  localparam int VT = VA + VB;

  logic          TFT_CLK = 1'b0;
  logic          reset;
  logic          power_req;
  logic [DW-1:0] pwm_duty;
  logic [CW-1:0] pix_r, pix_g, pix_b;
  logic          pix_req, frame_start, TFT_EN, TFT_DISP, TFT_DE, LED_EN;
  logic [CW-1:0] TFT_R, TFT_G, TFT_B;
  logic [2:0]    pwr_state;

  tft_timing_ctrl #(
    .COLOR_W(CW), .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
    .T1_CYC(T1), .T2_CYC(T2), .T3_CYC(T3), .T4_CYC(T4), .PWM_PERIOD(PP), .DUTY_W(DW)
  ) dut (
    .TFT_CLK(TFT_CLK), .reset(reset), .power_req(power_req), .pwm_duty(pwm_duty),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_req(pix_req), .frame_start(frame_start), .TFT_EN(TFT_EN), .TFT_DISP(TFT_DISP),
    .TFT_DE(TFT_DE), .LED_EN(LED_EN), .TFT_R(TFT_R), .TFT_G(TFT_G), .TFT_B(TFT_B),
    .pwr_state(pwr_state)
  );

  always #5 TFT_CLK = ~TFT_CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: phase plus timestamps (cycle of reset, of phase entry, of data start).
  int  m_state, m_entry, m_tstart, m_rst, m_duty;
  bit  m_disp;
  bit  e_de, e_led;
  logic [CW-1:0] e_r, e_g, e_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_pix(input int n);
    int h, v;
    if (!(m_state >= 2 && m_state <= 4)) return 1'b0;
    h = (n - m_tstart) % HT;
    v = ((n - m_tstart) / HT) % VT;
    return (h < HA) && (v < VA);
  endfunction

  function automatic bit m_fs(input int n);
    return m_pix(n) && (((n - m_tstart) % (HT * VT)) == 0);
  endfunction

  task automatic check_all();
    chk("pwr_state", pwr_state, m_state);
    chk("TFT_EN", TFT_EN, (m_state >= 1 && m_state <= 5));
    chk("TFT_DISP", TFT_DISP, (m_state == 3 || m_state == 4 || (m_state == 5 && m_disp)));
    chk("pix_req", pix_req, m_pix(cyc));
    chk("frame_start", frame_start, m_fs(cyc));
    chk("TFT_DE", TFT_DE, e_de);
    chk("TFT_R", TFT_R, e_r);
    chk("TFT_G", TFT_G, e_g);
    chk("TFT_B", TFT_B, e_b);
    chk("LED_EN", LED_EN, e_led);
  endtask

  // One clock: predict next outputs from current inputs, clock, then compare.
  task automatic step();
    int k, dur, nxt;
    bit pr, n_de, n_led;
    logic [CW-1:0] n_r, n_g, n_b;
    k   = cyc;
    pr  = m_pix(k);
    dur = k - m_entry + 1;
    nxt = m_state;
    n_led = 1'b0;
    if (reset) begin
      nxt = 0; n_de = 1'b0; n_r = '0; n_g = '0; n_b = '0;
    end else begin
      case (m_state)
        0: nxt = power_req ? 1 : 0;
        1: nxt = !power_req ? 5 : ((dur == T1) ? 2 : 1);
        2: nxt = !power_req ? 5 : ((dur == T2) ? 3 : 2);
        3: nxt = !power_req ? 5 : ((dur == T3) ? 4 : 3);
        4: nxt = !power_req ? 5 : 4;
        5: nxt = (dur == T3) ? 6 : 5;
        6: nxt = (dur == T4) ? 0 : 6;
        default: nxt = 0;
      endcase
      n_de = pr;
      n_r = pr ? pix_r : '0;
      n_g = pr ? pix_g : '0;
      n_b = pr ? pix_b : '0;
      if (((k - m_rst) % PP) == 0) m_duty = int'(pwm_duty);
      n_led = (m_state == 4) && (((k - m_rst) % PP) < m_duty);
    end
    @(posedge TFT_CLK);
    #1;
    cyc++;
    if (reset) begin
      m_rst = cyc; m_state = 0; m_entry = cyc; m_disp = 1'b0;
    end else begin
      if (nxt != m_state) begin
        m_entry = cyc;
        if (nxt == 2) m_tstart = cyc;
        if (nxt == 5) m_disp = (m_state == 3 || m_state == 4);
      end
      m_state = nxt;
    end
    e_de = n_de; e_r = n_r; e_g = n_g; e_b = n_b; e_led = n_led;
    check_all();
    pix_r = CW'($urandom);
    pix_g = CW'($urandom);
    pix_b = CW'($urandom);
  endtask

  initial begin
    int t0, f_en, f_pix, f_disp, f_run, f_led, cnt, n, t5, toff;
    reset = 1'b1; power_req = 1'b0; pwm_duty = '0;
    pix_r = '0; pix_g = '0; pix_b = '0;
    @(posedge TFT_CLK);
    #1;
    cyc = 0; m_rst = 0; m_state = 0; m_entry = 0; m_tstart = 0; m_disp = 1'b0; m_duty = 0;
    e_de = 1'b0; e_led = 1'b0; e_r = '0; e_g = '0; e_b = '0;
    check_all();
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Power-up sequence offsets from the power_req rise.
    pwm_duty = DW'(8);
    for (int i = 0; i < 9; i++) step();
    t0 = cyc; power_req = 1'b1;
    f_en = -1; f_pix = -1; f_disp = -1; f_run = -1; f_led = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (f_en   < 0 && TFT_EN    === 1'b1) f_en   = cyc - t0;
      if (f_pix  < 0 && pix_req   === 1'b1) f_pix  = cyc - t0;
      if (f_disp < 0 && TFT_DISP  === 1'b1) f_disp = cyc - t0;
      if (f_run  < 0 && pwr_state === 3'd4) f_run  = cyc - t0;
      if (f_led  < 0 && LED_EN    === 1'b1) f_led  = cyc - t0;
    end
    chk("en_delay", f_en, 1);
    chk("pix_delay", f_pix, 6);
    chk("disp_delay", f_disp, 9);
    chk("run_delay", f_run, 15);
    chk("led_delay", f_led, 16);

    // Pixel requests per line / frame and frame_start period.
    n = 0;
    while (frame_start !== 1'b1 && n < 30) begin step(); n++; end
    chk("frame_start_seen", frame_start, 1);
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      if (pix_req === 1'b1) cnt++;
      if (i == 5) chk("pix_per_line", cnt, 4);
      step();
    end
    chk("pix_per_frame", cnt, 12);
    chk("frame_period", frame_start, 1);

    // PWM duty cases.
    pwm_duty = DW'(3);
    for (int i = 0; i < 16; i++) step();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin if (LED_EN === 1'b1) cnt++; step(); end
    chk("pwm_duty3", cnt, 3);
    pwm_duty = DW'(0);
    for (int i = 0; i < 16; i++) step();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin if (LED_EN === 1'b1) cnt++; step(); end
    chk("pwm_duty0", cnt, 0);
    pwm_duty = DW'(8);
    for (int i = 0; i < 16; i++) step();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin if (LED_EN === 1'b1) cnt++; step(); end
    chk("pwm_duty8", cnt, 16);
    for (int j = 0; j < 4; j++) begin
      pwm_duty = DW'($urandom_range(0, 10));
      for (int i = 0; i < 20; i++) step();
    end

    // Reset while running with power_req held high.
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_state", pwr_state, 0);
    chk("rst_en", TFT_EN, 0);
    chk("rst_led", LED_EN, 0);
    chk("rst_de", TFT_DE, 0);
    step();
    chk("rst_restart", pwr_state, 1);
    for (int i = 0; i < 20; i++) step();

    // Orderly power-down from RUN.
    power_req = 1'b0;
    for (int i = 0; i < 14; i++) step();
    chk("powerdown_off", pwr_state, 0);

    // Abort in DISP_WAIT.
    power_req = 1'b1;
    n = 0;
    while (pwr_state !== 3'd2 && n < 20) begin step(); n++; end
    chk("reach_disp_wait", pwr_state, 2);
    power_req = 1'b0;
    t5 = -1; toff = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (t5 < 0 && pwr_state === 3'd5) begin
        t5 = cyc;
        chk("abort_disp", TFT_DISP, 0);
        chk("abort_led", LED_EN, 0);
      end
      if (toff < 0 && t5 >= 0 && pwr_state === 3'd0) toff = cyc;
    end
    chk("abort_to_off", toff - t5, 10);

    // Random power_req pulses of varying length.
    for (int j = 0; j < 6; j++) begin
      power_req = 1'b1;
      n = $urandom_range(1, 30);
      for (int i = 0; i < n; i++) step();
      power_req = 1'b0;
      for (int i = 0; i < 22; i++) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
